// File: rtl/e_mdu.sv
// E-stage multiply/divide sequencer: owns HI/LO, stages a launched result and commits it
// after MULT_CYCLES/DIV_CYCLES busy cycles. Define MDU_MADD_EN to enable madd/maddu/msub/msubu.
module e_mdu #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Src_A,
    input  logic [31:0] Src_B,
    input  logic [3:0]  MDUOp,
    input  logic        start,
    input  logic        req,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MDUOut
);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] hi_n_q, hi_n_d, lo_n_q, lo_n_d;
    logic        dz_q, dz_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;

    logic        is_mult, is_div, op_signed, is_acc, is_sub;
    logic [63:0] a_ext, b_ext, prod, mult_res;
    logic [31:0] a_abs, b_abs, divisor, uquo, urem, quo, rem;
    logic        div_zero;

    always_comb begin
        is_mult   = 1'b0;
        is_div    = 1'b0;
        op_signed = 1'b0;
        is_acc    = 1'b0;
        is_sub    = 1'b0;
        case (MDUOp)
            4'd1: begin is_mult = 1'b1; op_signed = 1'b1; end
            4'd2: is_mult = 1'b1;
            4'd3: begin is_div = 1'b1; op_signed = 1'b1; end
            4'd4: is_div = 1'b1;
`ifdef MDU_MADD_EN
            4'd9:  begin is_mult = 1'b1; op_signed = 1'b1; is_acc = 1'b1; end
            4'd10: begin is_mult = 1'b1; is_acc = 1'b1; end
            4'd11: begin is_mult = 1'b1; op_signed = 1'b1; is_acc = 1'b1; is_sub = 1'b1; end
            4'd12: begin is_mult = 1'b1; is_acc = 1'b1; is_sub = 1'b1; end
`endif
            default: ;
        endcase
    end

    // Low 64 bits of a 64x64 product of sign/zero-extended operands are exact for both signednesses.
    always_comb begin
        a_ext = op_signed ? {{32{Src_A[31]}}, Src_A} : {32'd0, Src_A};
        b_ext = op_signed ? {{32{Src_B[31]}}, Src_B} : {32'd0, Src_B};
        prod  = a_ext * b_ext;
        if (!is_acc) begin
            mult_res = prod;
        end else if (is_sub) begin
            mult_res = {hi_q, lo_q} - prod;
        end else begin
            mult_res = {hi_q, lo_q} + prod;
        end
    end

    // Signed division via magnitudes; -2^31 / -1 naturally wraps back to 0x80000000.
    always_comb begin
        div_zero = (Src_B == 32'd0);
        a_abs    = (op_signed && Src_A[31]) ? (32'd0 - Src_A) : Src_A;
        b_abs    = (op_signed && Src_B[31]) ? (32'd0 - Src_B) : Src_B;
        divisor  = div_zero ? 32'd1 : b_abs;
        uquo     = a_abs / divisor;
        urem     = a_abs % divisor;
        quo      = (op_signed && (Src_A[31] ^ Src_B[31])) ? (32'd0 - uquo) : uquo;
        rem      = (op_signed && Src_A[31]) ? (32'd0 - urem) : urem;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_n_d  = hi_n_q;
        lo_n_d  = lo_n_q;
        dz_d    = dz_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        unique case (state_q)
            StIdle: begin
                if (!req) begin
                    if (start && is_mult) begin
                        {hi_n_d, lo_n_d} = mult_res;
                        dz_d    = 1'b0;
                        cnt_d   = 4'(MULT_CYCLES);
                        state_d = StRun;
                    end else if (start && is_div) begin
                        hi_n_d  = rem;
                        lo_n_d  = quo;
                        dz_d    = div_zero;
                        cnt_d   = 4'(DIV_CYCLES);
                        state_d = StRun;
                    end else if (MDUOp == 4'd7) begin
                        hi_d = Src_A;
                    end else if (MDUOp == 4'd8) begin
                        lo_d = Src_A;
                    end
                end
            end
            StRun: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    cnt_d   = 4'd0;
                    state_d = StIdle;
                    if (!dz_q) begin
                        hi_d = hi_n_q;
                        lo_d = lo_n_q;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            hi_n_q  <= 32'd0;
            lo_n_q  <= 32'd0;
            dz_q    <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_n_q  <= hi_n_d;
            lo_n_q  <= lo_n_d;
            dz_q    <= dz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    always_comb begin
        busy = (state_q == StRun);
        HI   = hi_q;
        LO   = lo_q;
        case (MDUOp)
            4'd5:    MDUOut = hi_q;
            4'd6:    MDUOut = lo_q;
            default: MDUOut = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_e_mdu.sv
// Self-checking bench for e_mdu: directed plan followed by random ops against a 64-bit
// arithmetic reference model of HI/LO.
module tb_e_mdu;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Src_A, Src_B;
    logic [3:0]  MDUOp;
    logic        start, req;
    logic        busy;
    logic [31:0] HI, LO, MDUOut;

    int tests = 0;
    int fails = 0;
    logic [31:0] m_hi, m_lo;

    e_mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .Src_A(Src_A), .Src_B(Src_B), .MDUOp(MDUOp),
        .start(start), .req(req), .busy(busy), .HI(HI), .LO(LO), .MDUOut(MDUOut)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_hilo(input string tag);
        chk({tag, "_HI"}, {32'd0, HI}, {32'd0, m_hi});
        chk({tag, "_LO"}, {32'd0, LO}, {32'd0, m_lo});
    endtask

    // Reference: what an op would do to {HI,LO}, from plain 64-bit arithmetic.
    task automatic model_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                            output bit launch, output int len, output bit dz,
                            output logic [31:0] nhi, output logic [31:0] nlo);
        longint          sa, sb, sq, sr;
        longint unsigned ua, ub;
        logic [63:0]     r, acc;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        acc = {m_hi, m_lo};
        launch = 1'b1;
        dz = 1'b0;
        len = MC;
        r = acc;
        case (op)
            4'd1: r = sa * sb;
            4'd2: r = ua * ub;
            4'd3, 4'd4: begin
                len = DC;
                if (b == 32'd0) begin
                    dz = 1'b1;
                end else if (op == 4'd3) begin
                    sq = sa / sb;
                    sr = sa % sb;
                    r = {sr[31:0], sq[31:0]};
                end else begin
                    r = {32'(ua % ub), 32'(ua / ub)};
                end
            end
`ifdef MDU_MADD_EN
            4'd9:  r = acc + 64'(sa * sb);
            4'd10: r = acc + 64'(ua * ub);
            4'd11: r = acc - 64'(sa * sb);
            4'd12: r = acc - 64'(ua * ub);
`endif
            default: begin launch = 1'b0; len = 0; end
        endcase
        nhi = r[63:32];
        nlo = r[31:0];
    endtask

    // Issue one op at a negedge, then follow busy until it drops and check HI/LO.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic rq);
        bit launch, dz;
        int len, n;
        logic [31:0] nhi, nlo;
        model_op(op, a, b, launch, len, dz, nhi, nlo);
        @(negedge clk);
        MDUOp = op; Src_A = a; Src_B = b; start = 1'b1; req = rq;
        chk({tag, "_busyT"}, {63'd0, busy}, 64'd0);
        @(negedge clk);
        start = 1'b0; req = 1'b0; MDUOp = 4'd0;
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
        end
        if (!rq) begin
            if (launch && !dz) begin m_hi = nhi; m_lo = nlo; end
            if (op == 4'd7) m_hi = a;
            if (op == 4'd8) m_lo = a;
        end
        chk({tag, "_len"}, 64'(n), (launch && !rq) ? 64'(len) : 64'd0);
        chk_hilo(tag);
        MDUOp = 4'd5;
        #1 chk({tag, "_mfhi"}, {32'd0, MDUOut}, {32'd0, m_hi});
        MDUOp = 4'd6;
        #1 chk({tag, "_mflo"}, {32'd0, MDUOut}, {32'd0, m_lo});
        MDUOp = 4'd0;
    endtask

    initial begin
        bit rq;
        logic [3:0] op;
        logic [31:0] a, b;
        int n;
        reset = 1'b1; Src_A = '0; Src_B = '0; MDUOp = '0; start = 1'b0; req = 1'b0;
        m_hi = '0; m_lo = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk_hilo("rst");
        chk("rst_mduout", {32'd0, MDUOut}, 64'd0);
        reset = 1'b0;

        run_op("mult", 4'd1, 32'hFFFF_FFFF, 32'd2, 1'b0);
        chk("mult_exact", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFE);
        run_op("multu", 4'd2, 32'hFFFF_FFFF, 32'd2, 1'b0);
        chk("multu_exact", {HI, LO}, 64'h0000_0001_FFFF_FFFE);
        run_op("div", 4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
        chk("div_exact", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op("divu0", 4'd4, 32'd5, 32'd0, 1'b0);
        chk("divu0_exact", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op("divovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        chk("divovf_exact", {HI, LO}, 64'h0000_0000_8000_0000);

        run_op("flush_mult", 4'd1, 32'd3, 32'd3, 1'b1);
        run_op("flush_mtlo", 4'd8, 32'h1234, 32'd0, 1'b1);
        run_op("mtlo", 4'd8, 32'h1234, 32'd0, 1'b0);
        chk("mtlo_exact", {32'd0, LO}, 64'h1234);

        // mult with mthi at busy cycle 2 and start div at busy cycle 3, both ignored.
        run_op("pre", 4'd1, 32'hFFFF_FFFF, 32'd2, 1'b0);
        @(negedge clk);
        MDUOp = 4'd1; Src_A = 32'd1000; Src_B = 32'd3000; start = 1'b1;
        @(negedge clk);
        start = 1'b0; MDUOp = 4'd0;
        chk("ign_b1", {63'd0, busy}, 64'd1);
        @(negedge clk);
        MDUOp = 4'd7; Src_A = 32'hAAAA;
        chk("ign_b2", {63'd0, busy}, 64'd1);
        @(negedge clk);
        MDUOp = 4'd3; Src_A = 32'd100; Src_B = 32'd7; start = 1'b1;
        chk("ign_b3", {63'd0, busy}, 64'd1);
        @(negedge clk);
        start = 1'b0; MDUOp = 4'd0;
        n = 3;
        while (busy === 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
        end
        chk("ign_len", 64'(n), 64'(MC));
        m_hi = 32'd0; m_lo = 32'd3_000_000;
        chk_hilo("ign");
        @(negedge clk);
        chk("ign_nodiv", {63'd0, busy}, 64'd0);

        // Reset at busy cycle 3 of a div discards the pending result.
        MDUOp = 4'd4; Src_A = 32'd77; Src_B = 32'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0; MDUOp = 4'd0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_hi = '0; m_lo = '0;
        chk("midrst_busy", {63'd0, busy}, 64'd0);
        chk_hilo("midrst");
        repeat (DC + 2) @(negedge clk);
        chk("midrst_late_busy", {63'd0, busy}, 64'd0);
        chk_hilo("midrst_late");

`ifdef MDU_MADD_EN
        run_op("mthi0", 4'd7, 32'd0, 32'd0, 1'b0);
        run_op("mtlo5", 4'd8, 32'd5, 32'd0, 1'b0);
        run_op("madd", 4'd9, 32'd3, 32'd4, 1'b0);
        chk("madd_exact", {HI, LO}, 64'd17);
        run_op("msubu", 4'd12, 32'd1, 32'd18, 1'b0);
        chk("msubu_exact", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFF);
`else
        run_op("madd_off", 4'd9, 32'd3, 32'd4, 1'b0);
`endif

        for (int i = 0; i < 40; i++) begin
            op = 4'($urandom_range(1, 12));
            a  = $urandom;
            b  = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 2) == 0) b = 32'($urandom_range(0, 9)) - 32'd4;
            rq = ($urandom_range(0, 4) == 0);
            run_op("rand", op, a, b, rq);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
